// File: rtl/coeff_loader.sv
// Coefficient memory loader: assembles a byte stream into DEPTH-bit words, writes
// them to addresses 0..WORDS-1, then reads them back and verifies an XOR checksum.
module coeff_loader #(
  parameter int DEPTH = 24,
  parameter int WORDS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     mem_ce,
  output logic                     mem_we,
  output logic [$clog2(WORDS)-1:0] mem_a,
  output logic [DEPTH-1:0]         mem_d,
  input  logic [DEPTH-1:0]         mem_q,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DEPTH-1:0]         checksum
);

  localparam int BYTES = DEPTH / 8;
  localparam int AW    = $clog2(WORDS);
  localparam int BCW   = $clog2(BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    VERIFY,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  logic [BCW-1:0]   byte_cnt;
  logic [AW-1:0]    word_cnt;
  logic [DEPTH-1:0] word;
  logic [DEPTH-1:0] readback;
  logic [DEPTH-1:0] word_next;

  // MSB-first: earlier bytes end up in the upper part of the word.
  assign word_next = (word << 8) | DEPTH'(s_data);

  // NOTE: all state and outputs live in this one clocked block and use non-blocking
  // assignments, so every output is a register and reflects the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      word     <= '0;
      readback <= '0;
      s_ready  <= 1'b0;
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_d    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      checksum <= '0;
    end else begin
      // NOTE: default assignment makes done a single-cycle pulse without extra logic.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            byte_cnt <= '0;
            word_cnt <= '0;
            checksum <= '0;
            readback <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            s_ready  <= 1'b1;
          end
        end

        LOAD: begin
          if (s_valid) begin
            word <= word_next;
            if (byte_cnt == BCW'(BYTES - 1)) begin
              state   <= WRITE;
              s_ready <= 1'b0;
              mem_ce  <= 1'b1;
              mem_we  <= 1'b1;
              mem_a   <= word_cnt;
              mem_d   <= word_next;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          checksum <= checksum ^ mem_d;
          word_cnt <= word_cnt + 1'b1;
          byte_cnt <= '0;
          mem_we   <= 1'b0;
          if (word_cnt == AW'(WORDS - 1)) begin
            state  <= VERIFY;
            mem_ce <= 1'b1;
            mem_a  <= '0;
          end else begin
            state   <= LOAD;
            mem_ce  <= 1'b0;
            s_ready <= 1'b1;
          end
        end

        VERIFY: begin
          // mem_q carries the word for the address issued in the previous cycle.
          if (mem_a != '0) readback <= readback ^ mem_q;
          if (mem_a == AW'(WORDS - 1)) begin
            state  <= FLUSH;
            mem_ce <= 1'b0;
          end else begin
            mem_a <= mem_a + 1'b1;
          end
        end

        FLUSH: begin
          readback <= readback ^ mem_q;
          err      <= (readback ^ mem_q) != checksum;
          done     <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Initiator-side controller for the coefficient memory port (ce/we/a/d/q, synchronous read, 1-cycle read latency).
- Accepts a byte stream from the host or config interface and assembles DEPTH-bit coefficient words. Writes them to addresses 0..WORDS-1.
- Then reads all words back and checks an XOR checksum, so the decision-tree engine only starts on a verified coefficient image.

Parameters:
DEPTH, 24, coefficient word width in bits; must be a multiple of 8 (BYTES = DEPTH/8)
WORDS, 5, number of coefficient words loaded/verified; must be >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  1-cycle request to begin a load; sampled only in IDLE
s_valid  in  1  input byte valid
s_data  in  8  input byte; MSB-first within each word
s_ready  out  1  loader accepts byte this cycle (transfer = s_valid & s_ready)
mem_ce  out  1  memory chip enable
mem_we  out  1  memory write enable
mem_a  out  $clog2(WORDS)  memory word address
mem_d  out  DEPTH  memory write data
mem_q  in  DEPTH  memory read data, valid the cycle after a ce=1/we=0 request
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse at end of verify
err  out  1  checksum mismatch flag; valid with done, held until next start
checksum  out  DEPTH  XOR of all written words; held until next start

Behaviour:
- Reset: the state goes to IDLE.
  - s_ready, mem_ce, mem_we, busy, done and err are 0.
  - mem_a, mem_d and checksum are 0.
  - Byte counter, word counter and both accumulators are 0.
  - Memory contents are not touched.
- Reset mid-operation aborts immediately. Any partially written image stays in memory, and done is not pulsed.
- States: IDLE, LOAD, WRITE, VERIFY, FLUSH, DONE.
- IDLE:
  - start=1 moves to LOAD and clears the byte counter, word counter, write checksum, readback checksum and err.
  - start is ignored in all other states.
- LOAD:
  - s_ready=1.
  - Each transfer shifts s_data into the word register: word = {word[DEPTH-9:0], s_data}.
  - Counts bytes. On the BYTES-th transfer, moves to WRITE. s_valid gaps stall with no side effect.
- WRITE (exactly 1 cycle):
  - s_ready=0, mem_ce=1, mem_we=1, mem_a=word counter, mem_d=assembled word.
  - checksum ^= word; word counter increments; byte counter clears.
  - If this was word WORDS-1, move to VERIFY with the address counter at 0; otherwise return to LOAD.
- VERIFY:
  - mem_ce=1, mem_we=0, mem_a=0..WORDS-1 on consecutive cycles, one address per cycle.
  - From the second VERIFY cycle on, readback ^= mem_q for the previous address.
  - After issuing address WORDS-1, move to FLUSH.
- FLUSH (1 cycle): mem_ce=0; readback ^= mem_q for address WORDS-1.
- DONE (1 cycle):
  - done=1; err = (readback != checksum).
  - Return to IDLE. err and checksum hold until the next accepted start.
- mem_ce=0 and mem_we=0 in IDLE, LOAD and DONE. mem_we is only ever high in WRITE.
- Bytes offered in any state other than LOAD are not accepted (s_ready=0). Excess stream bytes wait for the next load.
- Cycle budget with s_valid held high:
  - Each word takes BYTES+1 cycles.
  - Verify takes WORDS+2 cycles (VERIFY, FLUSH, DONE).
  - Start-to-done for defaults: 1 + 5*4 + 7 = 28 cycles.

Test Plan:
- Basic load: defaults, start, stream 00 00 01 00 00 02 00 00 04 00 00 08 00 00 10 with s_valid continuous. Required response:
  - Writes at addr 0..4 of 0x000001, 0x000002, 0x000004, 0x000008, 0x000010.
  - Then reads of addr 0..4.
  - done pulse 28 cycles after start, err=0, checksum=0x00001F.
- Backpressure: same bytes with s_valid low every other cycle -> identical memory writes and checksum; only timing stretches; no byte lost or duplicated.
- Corruption: bench overwrites memory word 2 with 0x000005 between the last WRITE and the first VERIFY read -> done with err=1, checksum still 0x00001F; err holds until the next start.
- Start while busy: pulse start during LOAD and during VERIFY -> no restart, counters unaffected, single done at the normal cycle.
- Reset mid-load: assert reset after 7 bytes -> next cycle all outputs 0 and the state is IDLE. A fresh start plus a full 15-byte stream then completes with err=0.
- Stream overrun: offer 18 bytes -> s_ready low after byte 15, bytes 16-18 remain pending, and no memory write occurs after WRITE of addr 4.
